// File: rtl/mest_disp_pkg.sv
// rtl/mest_disp_pkg.sv - shared types, glyph table and hex decode for the result display
package mest_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/mest_result_display_if.sv
// rtl/mest_result_display_if.sv - result stream from mest_pro plus board clear
interface mest_result_display_if;
    logic [7:0] i_result;
    logic       i_valid_result;
    logic       i_carry;
    logic       i_zero_flag;
    logic       i_all_done;
    logic       i_clear;

    modport master (
        output i_result, i_valid_result, i_carry, i_zero_flag, i_all_done, i_clear
    );

    modport slave (
        input  i_result, i_valid_result, i_carry, i_zero_flag, i_all_done, i_clear
    );
endinterface

// File: rtl/mest_seg_scanner.sv
// rtl/mest_seg_scanner.sv - time-multiplexed 4-digit active-low seven-segment driver
module mest_seg_scanner
    import mest_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_DIGITS-1:0][3:0]      nibbles,
    input  logic [NUM_DIGITS-1:0]           dp_lit,
    input  logic                            force_dash,
    output logic [6:0]                      o_seg,
    output logic                            o_dp,
    output logic [NUM_DIGITS-1:0]           o_an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    if (NUM_DIGITS != 4) begin : g_bad_digits
        $error("mest_seg_scanner supports exactly 4 digits");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [1:0]       digit_nxt;
    logic             wrap;

    // Next digit is computed ahead so anode and segments register on the same edge
    always_comb begin
        wrap      = (refresh_cnt == CNT_LAST);
        digit_nxt = wrap ? digit_idx + 2'd1 : digit_idx;
    end

    // Refresh counter, digit index and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            o_an        <= 4'b1110;
            o_seg       <= SEG_DASH;
            o_dp        <= 1'b1;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            digit_idx   <= digit_nxt;
            o_an        <= ~(4'b0001 << digit_nxt);
            o_seg       <= force_dash ? SEG_DASH : hex_to_seg(nibbles[digit_nxt]);
            o_dp        <= force_dash ? 1'b1 : ~dp_lit[digit_nxt];
        end
    end

endmodule

// File: rtl/mest_result_display.sv
// rtl/mest_result_display.sv - captures mest_pro results and shows them on a 4-digit display
module mest_result_display
    import mest_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    mest_result_display_if.slave  res,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [7:0]            o_count,
    output logic                  o_done
);

    if (NUM_DIGITS != 4) begin : g_bad_digits
        $error("mest_result_display supports exactly 4 digits");
    end

    state_t     state;
    state_t     state_nxt;
    logic [7:0] last_result;
    logic       last_carry;
    logic       last_zero;
    logic       capture;

    // Results are only accepted before completion, and clear overrides them
    assign capture = (state != DONE) && res.i_valid_result && !res.i_clear;

    // FSM state register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: clear wins, completion beats a simultaneous first result
    always_comb begin
        state_nxt = state;
        if (res.i_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (res.i_all_done)          state_nxt = DONE;
                    else if (res.i_valid_result) state_nxt = RUN;
                end
                RUN: begin
                    if (res.i_all_done) state_nxt = DONE;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Captured result, flags and saturating result count
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_result <= 8'h00;
            last_carry  <= 1'b0;
            last_zero   <= 1'b0;
            o_count     <= 8'h00;
        end else if (res.i_clear) begin
            last_result <= 8'h00;
            last_carry  <= 1'b0;
            last_zero   <= 1'b0;
            o_count     <= 8'h00;
        end else if (capture) begin
            last_result <= res.i_result;
            last_carry  <= res.i_carry;
            last_zero   <= res.i_zero_flag;
            o_count     <= (o_count == 8'hFF) ? o_count : o_count + 8'd1;
        end
    end

    assign o_done = (state == DONE);

    mest_seg_scanner #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (i_reset_n),
        .nibbles    ({o_count[7:4], o_count[3:0], last_result[7:4], last_result[3:0]}),
        .dp_lit     ({o_done, 1'b0, last_zero, last_carry}),
        .force_dash (state == IDLE),
        .o_seg      (o_seg),
        .o_dp       (o_dp),
        .o_an       (o_an)
    );

endmodule
